data_write_buffer: RTL
======================

Name: data_write_buffer

Overview:
- Posted-write FIFO between the data-side 2x1 bridge and the data port of the SRAM-like-to-AXI interface.
- Write-through D-cache stores and uncached stores complete to the core one cycle after acceptance. Buffered writes then drain to memory in order, in the background.
- Reads are held until the buffer is fully drained, so read-after-write ordering is always correct. A read is then passed straight through to the downstream port.
- Both sides use the SRAM-like protocol: req, wr, size, addr, wdata, rdata, addr_ok, data_ok.

Parameters:
DEPTH, 4, number of write entries; must be a power of 2 and at least 2.
PTR_W, 2, log2(DEPTH); width of the read and write pointers.

Ports:
clk  in  1  clock; all state updates on the rising edge
resetn  in  1  synchronous reset, active low
cpu_req  in  1  upstream request valid
cpu_wr  in  1  1 = write, 0 = read
cpu_size  in  2  0 = byte, 1 = half, 2 = word
cpu_addr  in  32  physical address
cpu_wdata  in  32  write data
cpu_rdata  out  32  read data, valid when cpu_data_ok is high
cpu_addr_ok  out  1  request accepted this cycle
cpu_data_ok  out  1  request completed
mem_req  out  1  downstream request valid
mem_wr  out  1  downstream write flag
mem_size  out  2  downstream size
mem_addr  out  32  downstream address
mem_wdata  out  32  downstream write data
mem_rdata  in  32  downstream read data
mem_addr_ok  in  1  downstream accept
mem_data_ok  in  1  downstream completion
wb_empty  out  1  1 when the FIFO is empty and the FSM is IDLE

Behaviour:
- Storage: DEPTH entries of {addr[31:0], size[1:0], wdata[31:0]}. State is wr_ptr, rd_ptr and count[PTR_W:0].
- Reset, sampled while resetn=0 at a rising edge:
  - pointers and count go to 0; FSM goes to IDLE; the write-ack register is cleared.
  - All outputs are 0, except wb_empty=1.
  - Reset during any state, including WR_WAIT and RD_WAIT, abandons the transaction; no replay.
- Write accept: cpu_addr_ok = cpu_req & cpu_wr & (count != DEPTH) & (state != RD_WAIT).
  - On accept at cycle T, the entry is written at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
  - cpu_data_ok goes high at T+1 for exactly 1 cycle.
  - The full test uses the registered count. A pop in the same cycle does not free a slot for a push in that cycle.
- FSM states: IDLE, WR_REQ, WR_WAIT, RD_WAIT.
  - IDLE, count>0: go to WR_REQ.
  - IDLE, count==0, cpu_req & ~cpu_wr: combinational pass-through.
    - mem_req=1, mem_wr=0, mem_addr/mem_size driven from cpu_*.
    - cpu_addr_ok = mem_addr_ok.
    - If mem_addr_ok, go to RD_WAIT.
  - IDLE, count>0, cpu_req & ~cpu_wr: cpu_addr_ok=0; the read stalls until the buffer drains.
  - WR_REQ: mem_req=1, mem_wr=1, mem_addr/mem_size/mem_wdata taken from the entry at rd_ptr. If mem_addr_ok, go to WR_WAIT.
  - WR_WAIT: mem_req=0. On mem_data_ok: pop the entry (rd_ptr+1, count-1).
    - Then go to WR_REQ if count>1 before the pop, else to IDLE.
    - A head entry is never popped before its data_ok.
  - RD_WAIT: cpu_addr_ok=0 for all requests. cpu_data_ok = mem_data_ok and cpu_rdata = mem_rdata, combinationally. On mem_data_ok, go to IDLE.
- Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance.
- Write latency: an entry accepted into an empty IDLE buffer at T produces mem_req at T+1 at the earliest.
- Read latency: with an empty buffer, zero added cycles.
- cpu_data_ok collision is impossible: a read can only be accepted when count==0, which is at least 2 cycles after the last write ack.
- Outputs outside the active states: mem_wr, mem_addr and mem_wdata are 0 when mem_req=0. cpu_rdata is 0 outside RD_WAIT.
- Pointer wrap: rd_ptr and wr_ptr wrap modulo DEPTH; full vs. empty is distinguished by count only.

Test Plan:
- Single write: write addr 0x1FC0_0010, wdata 0xDEAD_BEEF, size 2 at T. Required: cpu_addr_ok at T, cpu_data_ok at T+1, and mem_req/mem_wr at T+1 with the same addr/data. With mem_addr_ok at T+1 and mem_data_ok at T+3, wb_empty=1 at T+4.
- Fill: mem_addr_ok held 0; 5 back-to-back writes to addr 0x0, 0x4, 0x8, 0xC, 0x10. Required: the first 4 are accepted and the 5th has cpu_addr_ok=0 until the first mem_data_ok. Memory then sees addresses in order 0x0, 0x4, 0x8, 0xC, 0x10.
- Read-after-write: 2 writes, then a read of 0x4. Required: cpu_addr_ok for the read stays 0 until both mem_data_ok pulses, and mem_req for the read appears only after that. rdata 0x1234_5678 from mem returns on cpu_rdata with cpu_data_ok in the same cycle.
- Push while popping at count=DEPTH-1 (3 entries, then a 4th write in the cycle of the head's mem_data_ok). Required: count stays 3, pointers wrap past DEPTH-1 correctly, and data order is preserved across 8 total writes.
- Reset mid-drain: resetn=0 for 1 cycle while in WR_WAIT with 3 entries. Required next cycle: mem_req=0, cpu_data_ok=0, wb_empty=1, and a new write is accepted normally.
- Read with empty buffer, mem_addr_ok delayed 3 cycles. Required: cpu_addr_ok mirrors mem_addr_ok, and a cpu write presented during RD_WAIT sees cpu_addr_ok=0 until the read's data_ok.

Source files
------------

// File: rtl/data_write_buffer.sv
// Posted-write buffer between the data-side bridge and the memory port.
// Stores are acknowledged early and drain in order; reads wait for an empty buffer.
module data_write_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [1:0]        cpu_size,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_addr_ok,
   output logic              cpu_data_ok,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   output logic              wb_empty
);

   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WR_REQ  = 2'd1;
   localparam logic [1:0] WR_WAIT = 2'd2;
   localparam logic [1:0] RD_WAIT = 2'd3;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [31:0]      addr_mem [DEPTH];
   logic [1:0]       size_mem [DEPTH];
   logic [31:0]      data_mem [DEPTH];

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             wr_ack;

   logic             push;
   logic             pop;
   logic             rd_pass;
   logic             rd_done;

   // Full test uses the registered count: a same-cycle pop never frees a slot.
   assign push    = cpu_req & cpu_wr & (count != FULL_CNT) & (state != RD_WAIT);
   assign pop     = (state == WR_WAIT) & mem_data_ok;
   assign rd_pass = (state == IDLE) & (count == '0) & cpu_req & ~cpu_wr;

   assign cpu_addr_ok = push | (rd_pass & mem_addr_ok);
   assign cpu_data_ok = wr_ack | rd_done;
   assign wb_empty    = (state == IDLE) & (count == '0);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            // A push into an empty buffer heads straight to WR_REQ next cycle.
            if ((count != '0) || push) begin
               state_nxt = WR_REQ;
            end else if (rd_pass && mem_addr_ok) begin
               state_nxt = RD_WAIT;
            end
         end
         WR_REQ: begin
            if (mem_addr_ok) begin
               state_nxt = WR_WAIT;
            end
         end
         WR_WAIT: begin
            if (mem_data_ok) begin
               state_nxt = (count != CNT_ONE) ? WR_REQ : IDLE;
            end
         end
         RD_WAIT: begin
            if (mem_data_ok) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_size  = 2'd0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      cpu_rdata = 32'd0;
      rd_done   = 1'b0;
      case (state)
         IDLE: begin
            if (rd_pass) begin
               mem_req  = 1'b1;
               mem_size = cpu_size;
               mem_addr = cpu_addr;
            end
         end
         WR_REQ: begin
            mem_req   = 1'b1;
            mem_wr    = 1'b1;
            mem_size  = size_mem[rd_ptr];
            mem_addr  = addr_mem[rd_ptr];
            mem_wdata = data_mem[rd_ptr];
         end
         RD_WAIT: begin
            cpu_rdata = mem_rdata;
            rd_done   = mem_data_ok;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state  <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         wr_ack <= 1'b0;
      end else begin
         state  <= state_nxt;
         wr_ack <= push;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push && !pop) begin
            count <= count + CNT_ONE;
         end else if (pop && !push) begin
            count <= count - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (resetn && push) begin
         addr_mem[wr_ptr] <= cpu_addr;
         size_mem[wr_ptr] <= cpu_size;
         data_mem[wr_ptr] <= cpu_wdata;
      end
   end

endmodule
